mux21_arbiter: RTL and testbench



---
 rtl/mux21_arbiter.sv | 140 ++++++++++++++
 tb/tb_mux21_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mux21_arbiter.sv
//==============================================================================
// Module   : mux21_arbiter (with mux21)
// Brief    : Round-robin, burst-locking arbiter that shares one 2:1 mux
//            between two valid/ready requesters and feeds one output register.
// Revision : 1.0
//==============================================================================
`default_nettype none

module mux21 #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sel,
    output logic [N-1:0] f
);
    assign f = sel ? b : a;
endmodule

module mux21_arbiter #(
    parameter int N        = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a_data,
    input  logic         a_valid,
    input  logic         a_last,
    output logic         a_ready,
    input  logic [N-1:0] b_data,
    input  logic         b_valid,
    input  logic         b_last,
    output logic         b_ready,
    output logic [N-1:0] f,
    output logic         f_valid,
    input  logic         f_ready,
    output logic         f_src,
    output logic         sel
);

    localparam int            CW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] c_CNT_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_A = 2'd1,
        S_GNT_B = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_gnt_q, last_gnt_d;   // 0 = A granted last, 1 = B
    logic [N-1:0]  f_q;
    logic          f_valid_q;
    logic          f_src_q;

    logic [N-1:0]  w_mux_f;
    logic          w_slot_free;
    logic          w_accept;
    logic          w_owner_last;

    mux21 #(.N(N)) u_mux (
        .a   (a_data),
        .b   (b_data),
        .sel (sel),
        .f   (w_mux_f)
    );

    assign sel          = (state_q == S_GNT_B);
    assign w_slot_free  = !f_valid_q || f_ready;
    assign a_ready      = (state_q == S_GNT_A) && w_slot_free;
    assign b_ready      = (state_q == S_GNT_B) && w_slot_free;
    assign w_accept     = (a_valid && a_ready) || (b_valid && b_ready);
    assign w_owner_last = sel ? b_last : a_last;

    assign f       = f_q;
    assign f_valid = f_valid_q;
    assign f_src   = f_src_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            S_IDLE: begin
                // A wins a tie only when B held the previous grant.
                if (a_valid && (!b_valid || last_gnt_q)) begin
                    state_d    = S_GNT_A;
                    last_gnt_d = 1'b0;
                    cnt_d      = '0;
                end else if (b_valid) begin
                    state_d    = S_GNT_B;
                    last_gnt_d = 1'b1;
                    cnt_d      = '0;
                end
            end
            S_GNT_A, S_GNT_B: begin
                if (w_accept) begin
                    if (w_owner_last || (cnt_q == c_CNT_MAX)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // A drain and a load in the same cycle keep the slot full with new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q       <= '0;
            f_valid_q <= 1'b0;
            f_src_q   <= 1'b0;
        end else if (w_accept) begin
            f_q       <= w_mux_f;
            f_valid_q <= 1'b1;
            f_src_q   <= sel;
        end else if (f_ready) begin
            f_valid_q <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mux21_arbiter.sv
//==============================================================================
// Module   : tb_mux21_arbiter
// Brief    : Randomized self-checking bench for mux21_arbiter against a
//            transaction-level ownership model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_mux21_arbiter;

    localparam int N        = 16;
    localparam int MAX_HOLD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] a_data, b_data;
    logic         a_valid, a_last, b_valid, b_last;
    logic         a_ready, b_ready;
    logic [N-1:0] f;
    logic         f_valid, f_ready, f_src, sel;

    int total = 0;
    int bad   = 0;

    // Model: who owns the datapath (0 none, 1 A, 2 B), beats taken this grant,
    // who was granted most recently, and the contents of the output slot.
    int           m_own  = 0;
    int           m_cnt  = 0;
    int           m_prev = 2;
    logic [N-1:0] m_f    = '0;
    logic         m_fv   = 1'b0;
    logic         m_src  = 1'b0;
    bit           a_took, b_took;

    mux21_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_last  (a_last),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_last  (b_last),
        .b_ready (b_ready),
        .f       (f),
        .f_valid (f_valid),
        .f_ready (f_ready),
        .f_src   (f_src),
        .sel     (sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare on the falling edge, advance the model on the rising edge,
    // then return 1 time unit later so the caller can drive new inputs.
    task automatic cycle();
        bit take;
        bit exp_ar, exp_br;
        @(negedge clk);
        exp_ar = (m_own == 1) && (!m_fv || f_ready);
        exp_br = (m_own == 2) && (!m_fv || f_ready);
        chk("sel",     sel,     (m_own == 2));
        chk("a_ready", a_ready, exp_ar);
        chk("b_ready", b_ready, exp_br);
        chk("f_valid", f_valid, m_fv);
        if (m_fv) begin
            chk("f",     f,     m_f);
            chk("f_src", f_src, m_src);
        end else if (m_f == '0 && !m_src) begin
            chk("f_rst", f, 32'h0);
        end
        @(posedge clk);
        a_took = 1'b0;
        b_took = 1'b0;
        if (rst) begin
            m_own = 0; m_cnt = 0; m_prev = 2;
            m_f = '0; m_fv = 1'b0; m_src = 1'b0;
        end else begin
            take = 1'b0;
            if (m_own == 1) take = a_valid && (!m_fv || f_ready);
            if (m_own == 2) take = b_valid && (!m_fv || f_ready);
            if (m_own == 0) begin
                if (a_valid && b_valid) m_own = (m_prev == 2) ? 1 : 2;
                else if (a_valid)       m_own = 1;
                else if (b_valid)       m_own = 2;
                if (m_own != 0) begin
                    m_prev = m_own;
                    m_cnt  = 0;
                end
            end else if (take) begin
                a_took = (m_own == 1);
                b_took = (m_own == 2);
                m_f    = a_took ? a_data : b_data;
                m_src  = b_took;
                m_cnt++;
                if ((a_took ? a_last : b_last) || m_cnt == MAX_HOLD) begin
                    m_own = 0;
                    m_cnt = 0;
                end
            end
            if (take)         m_fv = 1'b1;
            else if (f_ready) m_fv = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; f_ready = 1'b1;
        a_valid = 1'b1; a_last = 1'b0; a_data = 16'h0101;
        b_valid = 1'b1; b_last = 1'b0; b_data = 16'h0202;

        // Reset held with both requesters active
        cycle(); cycle();
        chk("rst_f_valid", f_valid, 1'b0);
        chk("rst_f",       f,       16'h0);
        chk("rst_sel",     sel,     1'b0);
        chk("rst_readies", {a_ready, b_ready}, 2'b00);
        rst = 1'b0;
        cycle();
        chk("first_tie_sel",   sel,     1'b0);
        chk("first_tie_ready", a_ready, 1'b1);

        // Single A stream of three beats
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        cycle();
        rst = 1'b0; a_valid = 1'b1; a_data = 16'h1111; a_last = 1'b0;
        cycle();
        cycle();
        chk("stream_1", f, 16'h1111);
        chk("stream_src", f_src, 1'b0);
        a_data = 16'h2222;
        cycle();
        chk("stream_2", f, 16'h2222);
        a_data = 16'h3333; a_last = 1'b1;
        cycle();
        chk("stream_3", f, 16'h3333);
        chk("stream_idle", a_ready, 1'b0);
        a_valid = 1'b0; a_last = 1'b0;
        cycle();

        // Randomized traffic with occasional mid-run resets
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            f_ready = ($urandom_range(0, 3) != 0);
            if (a_took || !a_valid || $urandom_range(0, 7) == 0) begin
                a_data  = N'($urandom);
                a_last  = ($urandom_range(0, 3) == 0);
                a_valid = ($urandom_range(0, 4) != 0);
            end
            if (b_took || !b_valid || $urandom_range(0, 7) == 0) begin
                b_data  = N'($urandom);
                b_last  = ($urandom_range(0, 3) == 0);
                b_valid = ($urandom_range(0, 4) != 0);
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
